mul_array_scheduler: RTL

- Sequences operand delivery to the F×I multiplier array for one tile of a convolution layer.
- Walks the activation-vector × weight-vector loop nest and issues read strobes and indices to the IARAM and weight buffers.
- Drives the array's mode select (sparse Cartesian product or dense broadcast) and asserts issue-valid aligned with the operand data.
- Obeys crossbar backpressure and reports busy/done to the layer controller.

---
 rtl/mul_array_scheduler_pkg.sv | 20 ++
 rtl/mul_sched_loop_cnt.sv | 38 +++
 rtl/mul_array_scheduler.sv | 109 ++++++++++
 3 files changed

// File: rtl/mul_array_scheduler_pkg.sv
// Shared types and sizing for the multiplier-array operand scheduler.
package mul_array_scheduler_pkg;

    localparam int F     = 4;   // weight lanes per issue
    localparam int I     = 4;   // activation lanes per issue
    localparam int CNT_W = 8;   // vector count / index width

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} sched_state_t;

    typedef struct packed {
        logic             sparse;
        logic [CNT_W-1:0] num_a_vec;
        logic [CNT_W-1:0] num_w_vec;
    } sched_cfg_t;

    function automatic logic cfg_empty(input sched_cfg_t cfg);
        return (cfg.num_a_vec == '0) || (cfg.num_w_vec == '0);
    endfunction

endpackage

// File: rtl/mul_sched_loop_cnt.sv
// Two-level nested counter: inner index wraps into an outer increment;
// last flags the final (outer, inner) pair of the nest.
module mul_sched_loop_cnt
    import mul_array_scheduler_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] num_outer,
    input  logic [CNT_W-1:0] num_inner,
    output logic [CNT_W-1:0] outer_idx,
    output logic [CNT_W-1:0] inner_idx,
    output logic             last
);

    logic inner_wrap;
    logic outer_wrap;

    assign inner_wrap = (inner_idx == num_inner - CNT_W'(1));
    assign outer_wrap = (outer_idx == num_outer - CNT_W'(1));
    assign last       = inner_wrap && outer_wrap;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            outer_idx <= '0;
            inner_idx <= '0;
        end else if (en) begin
            if (inner_wrap) begin
                inner_idx <= '0;
                outer_idx <= outer_wrap ? '0 : outer_idx + CNT_W'(1);
            end else begin
                inner_idx <= inner_idx + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mul_array_scheduler.sv
// Walks the activation x weight loop nest for one tile and issues buffer reads
// to the multiplier array. Define MUL_SCHED_PERF_CNT_EN for issue/stall counters.
module mul_array_scheduler
    import mul_array_scheduler_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sparse_mode,
    input  logic [CNT_W-1:0] num_a_vec,
    input  logic [CNT_W-1:0] num_w_vec,
    input  logic             xbar_ready,
    output logic             a_rd_en,
    output logic [CNT_W-1:0] a_rd_idx,
    output logic             w_rd_en,
    output logic [CNT_W-1:0] w_rd_idx,
    output logic             mul_sparse,
    output logic             mul_issue,
    output logic             busy,
    output logic             done
`ifdef MUL_SCHED_PERF_CNT_EN
    ,
    output logic [31:0]      perf_issue_cnt,
    output logic [31:0]      perf_stall_cnt
`endif
);

    localparam int RD_LAT = 1;

    sched_state_t state, state_nxt;
    sched_cfg_t   cfg;
    logic         start_q;
    logic         accept;
    logic [1:0]   drain_cnt;
    logic         issue;
    logic         cnt_clr;
    logic         last;

    // Start is registered together with the tile config; a second start
    // while one is pending or a tile is running is dropped.
    assign accept = start && (state == IDLE) && !start_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            start_q   <= 1'b0;
            cfg       <= '0;
            drain_cnt <= '0;
            mul_issue <= 1'b0;
        end else begin
            state     <= state_nxt;
            start_q   <= accept;
            mul_issue <= issue;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
            if (accept) cfg <= '{sparse: sparse_mode, num_a_vec: num_a_vec, num_w_vec: num_w_vec};
        end
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        cnt_clr   = 1'b0;
        case (state)
            IDLE: if (start_q) begin
                cnt_clr   = 1'b1;
                state_nxt = cfg_empty(cfg) ? DONE : RUN;
            end
            RUN: begin
                issue = xbar_ready;
                if (xbar_ready && last) state_nxt = DRAIN;
            end
            // buffer read plus multiplier register
            DRAIN: if (drain_cnt == 2'(RD_LAT)) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    mul_sched_loop_cnt u_loop (
        .clk       (clk),
        .rst       (rst),
        .clr       (cnt_clr),
        .en        (issue),
        .num_outer (cfg.num_a_vec),
        .num_inner (cfg.num_w_vec),
        .outer_idx (a_rd_idx),
        .inner_idx (w_rd_idx),
        .last      (last)
    );

    assign a_rd_en    = issue;
    assign w_rd_en    = issue;
    assign mul_sparse = cfg.sparse;
    assign busy       = start_q || (state == RUN) || (state == DRAIN);
    assign done       = (state == DONE);

`ifdef MUL_SCHED_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && start_q)) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (issue) perf_issue_cnt <= perf_issue_cnt + 32'd1;
            if (state == RUN && !xbar_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule
